fifo_stream_reader: RTL and testbench

FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

---
 rtl/fifo_stream_reader.sv | 109 ++++++++++
 tb/tb_fifo_stream_reader.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - FIFO-to-stream reader with 3-entry skid buffer; optional m_last via READER_LAST_EN
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int PKT_LEN    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
`ifdef READER_LAST_EN
  output logic                  m_last,
`endif
  output logic [15:0]           beat_cnt
);

  // Three buffer slots used as a ring; rd_ptr is the head, wr_ptr the next free slot.
  logic [DATA_WIDTH-1:0] slot0, slot1, slot2;
  logic [1:0]            rd_ptr, wr_ptr;
  logic [1:0]            occ;
  logic                  inflight;
  logic                  beat;
  logic                  land;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Read request looks only at registered occupancy so m_ready never reaches fifo_rd_en.
  always_comb begin
    fifo_rd_en = !reset && !fifo_empty && (({1'b0, occ} + {2'b00, inflight}) < 3'd3);
    m_valid    = (occ != 2'd0);
    beat       = m_valid && m_ready;
    land       = inflight;
  end

  // Head-of-buffer selection for the stream output.
  always_comb begin
    m_data = slot0;
    case (rd_ptr)
      2'd1:    m_data = slot1;
      2'd2:    m_data = slot2;
      default: m_data = slot0;
    endcase
  end

  // Buffer, pointers, occupancy, in-flight flag and beat counter; reset wins over landing and beats.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot0    <= '0;
      slot1    <= '0;
      slot2    <= '0;
      rd_ptr   <= 2'd0;
      wr_ptr   <= 2'd0;
      occ      <= 2'd0;
      inflight <= 1'b0;
      beat_cnt <= 16'd0;
    end else begin
      inflight <= fifo_rd_en;
      if (land) begin
        case (wr_ptr)
          2'd1:    slot1 <= fifo_data;
          2'd2:    slot2 <= fifo_data;
          default: slot0 <= fifo_data;
        endcase
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (beat) begin
        rd_ptr   <= ptr_inc(rd_ptr);
        beat_cnt <= beat_cnt + 16'd1;
      end
      case ({land, beat})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

`ifdef READER_LAST_EN
  localparam int PKT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  logic [PKT_W-1:0] pkt_cnt;

  // Marks the head beat that closes a packet.
  always_comb begin
    m_last = m_valid && (pkt_cnt == PKT_W'(PKT_LEN - 1));
  end

  // Position of the head beat within its packet, advancing on every completed beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_cnt <= '0;
    end else if (beat) begin
      if (pkt_cnt == PKT_W'(PKT_LEN - 1)) begin
        pkt_cnt <= '0;
      end else begin
        pkt_cnt <= pkt_cnt + PKT_W'(1);
      end
    end
  end
`else
  logic unused_pkt_len;
  assign unused_pkt_len = (PKT_LEN > 0);
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb/tb_fifo_stream_reader.sv - self-checking bench for fifo_stream_reader
module tb_fifo_stream_reader;
  localparam int DW = 8;
  localparam int PL = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          fifo_empty = 1'b1;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_data = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic [15:0]   beat_cnt;
`ifdef READER_LAST_EN
  logic          m_last;
`endif

  int total = 0;
  int bad = 0;

  // source FIFO contents and the abstract model of the reader
  logic [DW-1:0] src_q[$];
  logic [DW-1:0] mdl_buf[$];
  logic          mdl_pend = 1'b0;
  logic [DW-1:0] mdl_pend_w = '0;
  logic [15:0]   mdl_cnt = 16'd0;
  int            mdl_pkt = 0;
  logic [DW-1:0] popped;

  logic s_reset = 1'b1;
  logic s_accept = 1'b0;
  logic s_ready = 1'b0;

  fifo_stream_reader #(.DATA_WIDTH(DW), .PKT_LEN(PL)) dut (
    .clk        (clk),
    .reset      (reset),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_data  (fifo_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
`ifdef READER_LAST_EN
    .m_last     (m_last),
`endif
    .beat_cnt   (beat_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // synchronous FIFO behaviour plus model update, just after each edge
  always @(posedge clk) begin
    #1;
    if (s_reset) begin
      mdl_buf.delete();
      mdl_cnt = 16'd0;
      mdl_pkt = 0;
    end else begin
      if (mdl_buf.size() != 0 && s_ready) begin
        void'(mdl_buf.pop_front());
        mdl_cnt = mdl_cnt + 16'd1;
        mdl_pkt = (mdl_pkt + 1) % PL;
      end
      if (mdl_pend) mdl_buf.push_back(mdl_pend_w);
    end
    mdl_pend = 1'b0;
    if (s_accept && src_q.size() != 0) begin
      popped = src_q.pop_front();
      fifo_data = popped;
      if (!s_reset) begin
        mdl_pend = 1'b1;
        mdl_pend_w = popped;
      end
    end
    fifo_empty = (src_q.size() == 0);
  end

  // every-cycle comparison against the model, mid-cycle
  always @(negedge clk) begin
    chk("m_valid", {31'd0, m_valid}, {31'd0, mdl_buf.size() != 0});
    if (mdl_buf.size() != 0) chk("m_data", {24'd0, m_data}, {24'd0, mdl_buf[0]});
    chk("beat_cnt", {16'd0, beat_cnt}, {16'd0, mdl_cnt});
    chk("fifo_rd_en", {31'd0, fifo_rd_en},
        {31'd0, !fifo_empty && !reset && ((mdl_buf.size() + int'(mdl_pend)) < 3)});
    chk("rd_while_empty", {31'd0, fifo_rd_en && fifo_empty}, 32'd0);
`ifdef READER_LAST_EN
    chk("m_last", {31'd0, m_last}, {31'd0, mdl_buf.size() != 0 && mdl_pkt == PL - 1});
`endif
    s_reset  = reset;
    s_accept = fifo_rd_en && !fifo_empty;
    s_ready  = m_ready;
  end

  initial begin
    int acc;
    int k;
    int c;
    logic          prev_stall;
    logic [DW-1:0] prev_data;
    logic          done;

    #1;
    chk("reset_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    tick();
    tick();
    chk("reset_valid", {31'd0, m_valid}, 32'd0);
    chk("reset_data", {24'd0, m_data}, 32'd0);
    chk("reset_cnt", {16'd0, beat_cnt}, 32'd0);
    reset = 1'b0;

    // preload 11..18, full throughput, first-word latency
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) src_q.push_back(8'(8'h11 + i));
    tick();
    chk("lat_empty_fell", {31'd0, fifo_empty}, 32'd0);
    chk("lat0_valid", {31'd0, m_valid}, 32'd0);
    tick();
    chk("lat1_valid", {31'd0, m_valid}, 32'd0);
    tick();
    chk("lat2_valid", {31'd0, m_valid}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      chk("t1_seq_valid", {31'd0, m_valid}, 32'd1);
      chk("t1_seq_data", {24'd0, m_data}, 32'(8'h11 + i));
      tick();
    end
    chk("t1_beat_cnt", {16'd0, beat_cnt}, 32'd8);

    // stall with 5 words queued, then drain
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) src_q.push_back(8'(8'h21 + i));
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      if (fifo_rd_en && !fifo_empty) acc++;
      tick();
    end
    chk("t2_accepts", acc, 32'd3);
    chk("t2_rd_en_low", {31'd0, fifo_rd_en}, 32'd0);
    chk("t2_hold_valid", {31'd0, m_valid}, 32'd1);
    chk("t2_hold_data", {24'd0, m_data}, 32'h21);
    m_ready = 1'b1;
    k = 0;
    for (int i = 0; i < 20 && k < 5; i++) begin
      if (m_valid) begin
        chk("t2_order", {24'd0, m_data}, 32'(8'h21 + k));
        k++;
      end
      tick();
    end
    chk("t2_delivered", k, 32'd5);
    chk("t2_beat_cnt", {16'd0, beat_cnt}, 32'd13);

    // m_ready toggling every cycle
    for (int i = 0; i < 16; i++) src_q.push_back(8'(8'h30 + i));
    k = 0;
    c = 0;
    prev_stall = 1'b0;
    prev_data = '0;
    while (c < 80 && k < 16) begin
      m_ready = c[0];
      if (prev_stall) chk("t3_stable", {24'd0, m_data}, {24'd0, prev_data});
      if (m_valid && m_ready) begin
        chk("t3_order", {24'd0, m_data}, 32'(8'h30 + k));
        k++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data = m_data;
      tick();
      c++;
    end
    chk("t3_delivered", k, 32'd16);

    // reset with two buffered words and one in flight
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) src_q.push_back(8'(8'h40 + i));
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (mdl_buf.size() == 2 && mdl_pend) done = 1'b1;
      else tick();
    end
    chk("t4_reached_state", {31'd0, done}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t4_valid_cleared", {31'd0, m_valid}, 32'd0);
    chk("t4_cnt_cleared", {16'd0, beat_cnt}, 32'd0);
    m_ready = 1'b1;
    k = 0;
    for (int i = 0; i < 20 && k < 2; i++) begin
      if (m_valid) begin
        chk("t4_order", {24'd0, m_data}, 32'(8'h43 + k));
        k++;
      end
      tick();
    end
    chk("t4_delivered", k, 32'd2);
    tick();
    tick();
    chk("t4_no_stale", {31'd0, m_valid}, 32'd0);

    // beat counter wrap
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 65536; i++) src_q.push_back(i[7:0]);
    done = 1'b0;
    for (int i = 0; i < 70000 && !done; i++) begin
      tick();
      if (src_q.size() == 0 && mdl_buf.size() == 0 && !mdl_pend && !m_valid) done = 1'b1;
    end
    chk("t5_drained", {31'd0, done}, 32'd1);
    chk("t5_wrap", {16'd0, beat_cnt}, 32'd0);

`ifdef READER_LAST_EN
    // packet markers with irregular stalls
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 12; i++) src_q.push_back(8'(8'h60 + i));
    k = 0;
    for (int i = 0; i < 100 && k < 12; i++) begin
      m_ready = (i % 3) != 1;
      if (m_valid && m_ready) begin
        k++;
        chk("t6_last", {31'd0, m_last}, {31'd0, (k % 4) == 0});
      end
      tick();
    end
    chk("t6_delivered", k, 32'd12);
`endif

    m_ready = 1'b0;
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
